decode_stage_pipe: RTL
======================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, data path width of register file, operands, immediate and pc.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of 2, 2..32); index width RW = log2(NREG).
REQ-003 Parameter LOAD_STALL, default 1, bubbles inserted per load-use hazard (range 1..3).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  fetch presents a valid instruction.
REQ-007 in_ready  out  1  decode accepts the instruction this cycle.
REQ-008 instruction  in  32  RV32I instruction word.
REQ-009 pc  in  XLEN  address of instruction.
REQ-010 flush  in  1  squash the instruction being accepted and any pending stall.
REQ-011 wb_we / wb_rd / wb_data  in  1 / 5 / XLEN  write-back port.
REQ-012 out_valid  out  1  ID/EX register holds a valid instruction.
REQ-013 out_data1, out_data2, out_imm, out_pc, out_pc_branch  out  XLEN each  registered operands, immediate, pc, branch target.
REQ-014 out_rs1, out_rs2, out_rd  out  5 each  registered register indices.
REQ-015 out_mem_read, out_reg_write  out  1 each  registered load flag, result-write flag.

Function
REQ-016 Register file: NREG x XLEN; write on rising edge when wb_we=1 and wb_rd!=0 and wb_rd<NREG; register 0 always reads 0; indices >=NREG read 0 and are never written.
REQ-017 Immediate: I, S, B, U, J formats decoded from opcode[6:0], sign-extended to XLEN; R-type and unknown opcodes give 0.
REQ-018 out_pc_branch = pc + imm, modulo 2^XLEN (B-type imm already has bit0=0; no extra shift).
REQ-019 out_mem_read=1 only for opcode 0000011; out_reg_write=1 for R, I-ALU, load, LUI, AUIPC, JAL, JALR with rd!=0.
REQ-020 Latency: instruction accepted at edge N appears on all out_* after edge N (1 cycle).
REQ-021 Load-use hazard: out_valid=1, out_mem_read=1, out_rd!=0, in_valid=1, and out_rd equals rs1 (instruction reads rs1) or rs2 (R, S, B types) -> stall counter loads LOAD_STALL.
REQ-022 Stall counter != 0 or hazard this cycle -> in_ready=0, ID/EX loaded with bubble (out_valid=0, all other out_* = 0); counter decrements by 1 per cycle to 0.
REQ-023 in_ready=1 and in_valid=1 and flush=0 -> ID/EX loads decoded instruction with out_valid=1.
REQ-024 in_valid=0 -> ID/EX loads bubble.
REQ-025 flush=1 -> next cycle ID/EX holds bubble and stall counter = 0; flush has priority over hazard and stall; in_ready=1 during flush.
REQ-026 Stall is state-holding only on the counter; fetch holds instruction/pc while in_ready=0.

Reset
REQ-027 rst=1 at edge: out_valid=0, all out_* = 0, stall counter = 0, all registers = 0.
REQ-028 Reset mid-stall abandons the stall; in_ready=1 in the first cycle after reset release.

Configuration
REQ-029 Macro DECODE_WB_BYPASS_EN defined: wb_we=1 and wb_rd==rs1 (rs2), non-zero -> read data for that operand is wb_data in the same cycle.
REQ-030 Macro DECODE_WB_BYPASS_EN undefined: the read returns the pre-write register value; the new value is visible from the next cycle.

Verification
REQ-031 Reset, then in_valid=1 with ADDI x5,x0,-3 at pc=0x100 -> next cycle out_valid=1, out_rd=5, out_imm=0xFFFFFFFD, out_reg_write=1, out_pc=0x100.
REQ-032 LW x6 accepted, then ADD x7,x6,x1, LOAD_STALL=2 -> in_ready=0 for 2 cycles, 2 bubbles, ADD appears on the 3rd cycle.
REQ-033 BEQ imm=-8 at pc=0x200 -> out_pc_branch=0x1F8.
REQ-034 wb_we=1, wb_rd=3, wb_data=0xA5, plus ADD reading x3 in the same cycle -> out_data1=0xA5 with macro defined; old value without macro.
REQ-035 flush=1 during a load-use stall -> bubble next cycle, in_ready=1, counter 0; write to x0 -> x0 still reads 0.

Source files
------------

// File: rtl/decode_stage_pipe_if.sv
// Fetch/write-back to decode handshake and the registered ID/EX outputs.
// master = fetch/pipeline driver, slave = decode stage.
interface decode_stage_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic            flush;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic [XLEN-1:0] out_data1;
    logic [XLEN-1:0] out_data2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_branch;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_mem_read;
    logic            out_reg_write;

    modport master (
        output in_valid, instruction, pc, flush, wb_we, wb_rd, wb_data,
        input  in_ready, out_valid, out_data1, out_data2, out_imm, out_pc,
               out_pc_branch, out_rs1, out_rs2, out_rd, out_mem_read, out_reg_write
    );

    modport slave (
        input  in_valid, instruction, pc, flush, wb_we, wb_rd, wb_data,
        output in_ready, out_valid, out_data1, out_data2, out_imm, out_pc,
               out_pc_branch, out_rs1, out_rs2, out_rd, out_mem_read, out_reg_write
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: register file, immediate decode, load-use stall, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle write-back data to the operand reads.
module decode_stage_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_pipe_if.slave bus
);

    localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0]  NREG_W = 6'(NREG);
    // The hazard cycle itself is the first bubble, so the counter holds the remainder.
    localparam logic [1:0]  STALL_RELOAD = 2'(LOAD_STALL - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            is_load;
    logic            reg_write;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            wr_en;
    logic            hazard;
    logic            stall;
    logic            load_instr;

    logic [XLEN-1:0] regs_q [NREG];

    logic [1:0]      stall_q;
    logic [1:0]      stall_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic [XLEN-1:0] out_data1_q;
    logic [XLEN-1:0] out_data1_d;
    logic [XLEN-1:0] out_data2_q;
    logic [XLEN-1:0] out_data2_d;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_imm_d;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_pc_d;
    logic [XLEN-1:0] out_pc_branch_q;
    logic [XLEN-1:0] out_pc_branch_d;
    logic [4:0]      out_rs1_q;
    logic [4:0]      out_rs1_d;
    logic [4:0]      out_rs2_q;
    logic [4:0]      out_rs2_d;
    logic [4:0]      out_rd_q;
    logic [4:0]      out_rd_d;
    logic            out_mem_read_q;
    logic            out_mem_read_d;
    logic            out_reg_write_q;
    logic            out_reg_write_d;

    assign instr  = bus.instruction;
    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        imm32     = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                imm32     = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            end
            OP_JALR, OP_IMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm32     = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm32     = {{20{instr[31]}}, instr[31:20]};
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_REG: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_write = writes_rd && (rd_f != '0);

    if (XLEN > 32) begin : g_imm_sext
        assign imm_x = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_trunc
        assign imm_x = imm32[XLEN-1:0];
    end

    // Register file: x0 and indices beyond NREG are hard-wired to zero.
    assign wr_en = bus.wb_we && (bus.wb_rd != '0) && ({1'b0, bus.wb_rd} < NREG_W);

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((rs1_f != '0) && ({1'b0, rs1_f} < NREG_W)) begin
            rdata1 = regs_q[rs1_f[RW-1:0]];
        end
        if ((rs2_f != '0) && ({1'b0, rs2_f} < NREG_W)) begin
            rdata2 = regs_q[rs2_f[RW-1:0]];
        end
`ifdef DECODE_WB_BYPASS_EN
        if (wr_en && (bus.wb_rd == rs1_f)) begin
            rdata1 = bus.wb_data;
        end
        if (wr_en && (bus.wb_rd == rs2_f)) begin
            rdata2 = bus.wb_data;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.wb_rd[RW-1:0]] <= bus.wb_data;
        end
    end

    // A bubble in ID/EX clears the hazard, so later stall cycles come from the counter alone.
    assign hazard = out_valid_q && out_mem_read_q && (out_rd_q != '0) && bus.in_valid &&
                    ((uses_rs1 && (out_rd_q == rs1_f)) || (uses_rs2 && (out_rd_q == rs2_f)));
    assign stall        = (stall_q != '0) || hazard;
    assign bus.in_ready = bus.flush || !stall;
    assign load_instr   = bus.in_valid && !bus.flush && !stall;

    always_comb begin
        stall_d = '0;
        if (bus.flush) begin
            stall_d = '0;
        end else if (hazard) begin
            stall_d = STALL_RELOAD;
        end else if (stall_q != '0) begin
            stall_d = stall_q - 2'd1;
        end
    end

    always_comb begin
        out_valid_d     = 1'b0;
        out_data1_d     = '0;
        out_data2_d     = '0;
        out_imm_d       = '0;
        out_pc_d        = '0;
        out_pc_branch_d = '0;
        out_rs1_d       = '0;
        out_rs2_d       = '0;
        out_rd_d        = '0;
        out_mem_read_d  = 1'b0;
        out_reg_write_d = 1'b0;
        if (load_instr) begin
            out_valid_d     = 1'b1;
            out_data1_d     = rdata1;
            out_data2_d     = rdata2;
            out_imm_d       = imm_x;
            out_pc_d        = bus.pc;
            out_pc_branch_d = bus.pc + imm_x;
            out_rs1_d       = rs1_f;
            out_rs2_d       = rs2_f;
            out_rd_d        = rd_f;
            out_mem_read_d  = is_load;
            out_reg_write_d = reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q         <= '0;
            out_valid_q     <= 1'b0;
            out_data1_q     <= '0;
            out_data2_q     <= '0;
            out_imm_q       <= '0;
            out_pc_q        <= '0;
            out_pc_branch_q <= '0;
            out_rs1_q       <= '0;
            out_rs2_q       <= '0;
            out_rd_q        <= '0;
            out_mem_read_q  <= 1'b0;
            out_reg_write_q <= 1'b0;
        end else begin
            stall_q         <= stall_d;
            out_valid_q     <= out_valid_d;
            out_data1_q     <= out_data1_d;
            out_data2_q     <= out_data2_d;
            out_imm_q       <= out_imm_d;
            out_pc_q        <= out_pc_d;
            out_pc_branch_q <= out_pc_branch_d;
            out_rs1_q       <= out_rs1_d;
            out_rs2_q       <= out_rs2_d;
            out_rd_q        <= out_rd_d;
            out_mem_read_q  <= out_mem_read_d;
            out_reg_write_q <= out_reg_write_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data1     = out_data1_q;
    assign bus.out_data2     = out_data2_q;
    assign bus.out_imm       = out_imm_q;
    assign bus.out_pc        = out_pc_q;
    assign bus.out_pc_branch = out_pc_branch_q;
    assign bus.out_rs1       = out_rs1_q;
    assign bus.out_rs2       = out_rs2_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_mem_read  = out_mem_read_q;
    assign bus.out_reg_write = out_reg_write_q;

endmodule
